pipe_ctrl_hazard: RTL and testbench
===================================

Name: pipe_ctrl_hazard

Overview:
- Consumer-side counterpart of the ID-stage control decoder in the 5-stage MIPS datapath.
- Takes the decoded ID control bundle and carries it through the EX, MEM and WB stage control registers.
- Detects load-use and branch-operand hazards and asserts stall and bubble insertion.
- Generates operand forwarding selects for the ID branch comparator and the EX ALU.

Parameters:
- RW_W, 5, register-address width.
- WB_W, 2, width of the write-back select field.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ID_RfWr  in  1  decoded register-file write enable.
- ID_DmWr  in  1  decoded data-memory write enable.
- ID_ReadMen  in  1  decoded load flag.
- ID_WbSel  in  WB_W  write-back source (00 DM, 01 ALU, 10 PC).
- ID_Rw  in  RW_W  resolved destination register.
- ID_Rs  in  RW_W  rs field of the instruction in ID.
- ID_Rt  in  RW_W  rt field of the instruction in ID.
- ID_UseRs  in  1  instruction in ID reads rs.
- ID_UseRt  in  1  instruction in ID reads rt.
- ID_IsBranch  in  1  branch or jr/jalr that is resolved in ID.
- Mem_Busy  in  1  data memory not ready; freezes the pipeline.
- Stall  out  1  hold PC and IF/ID register.
- EX_RfWr, EX_DmWr, EX_ReadMen  out  1 each  EX-stage control.
- EX_WbSel  out  WB_W  EX-stage write-back select.
- EX_Rw  out  RW_W  EX-stage destination.
- MEM_RfWr, MEM_DmWr, MEM_ReadMen  out  1 each  MEM-stage control.
- MEM_WbSel  out  WB_W  MEM-stage write-back select.
- MEM_Rw  out  RW_W  MEM-stage destination.
- WB_RfWr  out  1  WB-stage register-file write enable.
- WB_WbSel  out  WB_W  WB-stage write-back select.
- WB_Rw  out  RW_W  WB-stage destination.
- FwdA_EX  out  2  EX ALU operand A select (00 RF, 01 MEM ALU result, 10 WB data).
- FwdB_EX  out  2  EX ALU operand B select, same encoding.
- FwdA_ID  out  2  ID branch comparator operand A select, same encoding.
- FwdB_ID  out  2  ID branch comparator operand B select, same encoding.
- Stall_Cnt  out  32  stall-cycle counter (see Optional Feature).

Behaviour:
- Stage registers:
  - EX, MEM and WB each hold {RfWr, DmWr, ReadMen, WbSel, Rw}; EX also holds Rs, Rt, UseRs and UseRt.
  - RfWr is captured as ID_RfWr && (ID_Rw != 0), so writes to r0 are never visible downstream.
- Reset: while rst_n is low, all stage fields are 0, Stall = 0, all Fwd outputs = 00 and Stall_Cnt = 0. Reset deassertion mid-operation restarts with empty (bubble) stages.
- Advance: with no stall and no freeze, on each clk edge ID→EX→MEM→WB, and the old WB content is dropped. Latency is 1 cycle per stage.
- Hazard matching: a hit means src != 0 && src == stage.Rw && stage.RfWr, evaluated for rs (gated by UseRs) and rt (gated by UseRt).
- Load-use: an EX.ReadMen hit on an ID source gives Stall = 1. On the next edge EX loads a bubble (all control 0) while MEM and WB advance and ID holds.
- Branch operands, when ID_IsBranch = 1:
  - Any EX hit stalls, since the EX result is not ready.
  - A MEM hit with MEM.ReadMen = 1 stalls.
  - Both insert a bubble as for load-use.
- Mem_Busy = 1: Stall = 1 and every stage register holds, with no bubble inserted. This takes priority over load-use and branch stalls in the same cycle. After Mem_Busy falls, hazard logic re-evaluates in that cycle.
- Forwarding, all combinational:
  - MEM is preferred over WB.
  - MEM is a legal forwarding source only when MEM.ReadMen = 0 and MEM.WbSel != 00.
  - WB data is always legal.
  - No hit gives 00.
  - The EX selects use EX.Rs and EX.Rt against MEM and WB; the ID selects use ID_Rs and ID_Rt against MEM and WB.
- Stall is purely combinational from the current stage contents and the ID inputs; it has no registered delay.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- When defined: Stall_Cnt increments by 1 on every clk edge where Stall = 1, wraps from 0xFFFFFFFF to 0, and resets to 0.
- When not defined: no counter register; Stall_Cnt is tied to 32'h0.

Test Plan:
- Reset check: hold rst_n = 0, drive ID_RfWr = 1 with ID_Rw = 5 → all outputs stay 0. Release rst_n → EX_Rw = 5 one edge later.
- Load-use stall: lw r3 in ID, then add reading r3 next cycle → Stall = 1 for exactly 1 cycle and EX holds a bubble (EX_RfWr = 0). Following cycle FwdA_EX = 10 (WB data).
- ALU forwarding from MEM: add r4, then sub using r4 as rt → FwdB_EX = 01, no stall.
- Branch on ALU result: addi r6, then beq r6,r0 → Stall = 1 for one cycle, then FwdA_ID = 01.
- Branch on load result: lw r7, then beq r7 → Stall = 1 for two cycles, then FwdA_ID = 10.
- Freeze and r0 masking:
  - Mem_Busy = 1 for 3 cycles with a load-use pending → stage registers unchanged and Stall = 1 throughout; the bubble is inserted only after Mem_Busy = 0.
  - With PIPE_STALL_CNT_EN defined, Stall_Cnt = 4 at the end.
  - Any write to r0 yields no forwarding and no stall.

Source files
------------

// File: rtl/pipe_ctrl_hazard.sv
// Pipeline control carrier (EX/MEM/WB) with load-use/branch hazard stalls and forwarding selects.
// Optional stall-cycle counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_ctrl_hazard #(
   parameter int RW_W = 5,
   parameter int WB_W = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ID_RfWr,
   input  logic            ID_DmWr,
   input  logic            ID_ReadMen,
   input  logic [WB_W-1:0] ID_WbSel,
   input  logic [RW_W-1:0] ID_Rw,
   input  logic [RW_W-1:0] ID_Rs,
   input  logic [RW_W-1:0] ID_Rt,
   input  logic            ID_UseRs,
   input  logic            ID_UseRt,
   input  logic            ID_IsBranch,
   input  logic            Mem_Busy,
   output logic            Stall,
   output logic            EX_RfWr,
   output logic            EX_DmWr,
   output logic            EX_ReadMen,
   output logic [WB_W-1:0] EX_WbSel,
   output logic [RW_W-1:0] EX_Rw,
   output logic            MEM_RfWr,
   output logic            MEM_DmWr,
   output logic            MEM_ReadMen,
   output logic [WB_W-1:0] MEM_WbSel,
   output logic [RW_W-1:0] MEM_Rw,
   output logic            WB_RfWr,
   output logic [WB_W-1:0] WB_WbSel,
   output logic [RW_W-1:0] WB_Rw,
   output logic [1:0]      FwdA_EX,
   output logic [1:0]      FwdB_EX,
   output logic [1:0]      FwdA_ID,
   output logic [1:0]      FwdB_ID,
   output logic [31:0]     Stall_Cnt
);

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwdSel_e;

   logic [RW_W-1:0] exRs, exRt;
   logic            exUseRs, exUseRt;
   logic            memLegal, ldUse, brStall, hazStall;
   logic            exHitRs, exHitRt, memHitRs, memHitRt;

   function automatic logic hit(input logic [RW_W-1:0] src, input logic useSrc,
                                input logic [RW_W-1:0] rw, input logic rfWr);
      return useSrc && (src != '0) && (src == rw) && rfWr;
   endfunction

   function automatic logic [1:0] fwdPick(input logic memHit, input logic wbHit);
      fwdSel_e sel;
      sel = memHit ? FWD_MEM : (wbHit ? FWD_WB : FWD_RF);
      return sel;
   endfunction

   always_comb begin
      exHitRs  = hit(ID_Rs, ID_UseRs, EX_Rw, EX_RfWr);
      exHitRt  = hit(ID_Rt, ID_UseRt, EX_Rw, EX_RfWr);
      memHitRs = hit(ID_Rs, ID_UseRs, MEM_Rw, MEM_RfWr);
      memHitRt = hit(ID_Rt, ID_UseRt, MEM_Rw, MEM_RfWr);
      memLegal = !MEM_ReadMen && (MEM_WbSel != '0);
      ldUse    = EX_ReadMen && (exHitRs || exHitRt);
      // Branch compares in ID, so any EX producer or a load still in MEM is too late to forward.
      brStall  = ID_IsBranch && (exHitRs || exHitRt || (MEM_ReadMen && (memHitRs || memHitRt)));
      hazStall = ldUse || brStall;
      Stall    = rst_n && (Mem_Busy || hazStall);

      FwdA_EX = fwdPick(memLegal && hit(exRs, exUseRs, MEM_Rw, MEM_RfWr),
                        hit(exRs, exUseRs, WB_Rw, WB_RfWr));
      FwdB_EX = fwdPick(memLegal && hit(exRt, exUseRt, MEM_Rw, MEM_RfWr),
                        hit(exRt, exUseRt, WB_Rw, WB_RfWr));
      FwdA_ID = fwdPick(memLegal && memHitRs, hit(ID_Rs, ID_UseRs, WB_Rw, WB_RfWr));
      FwdB_ID = fwdPick(memLegal && memHitRt, hit(ID_Rt, ID_UseRt, WB_Rw, WB_RfWr));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         EX_RfWr     <= 1'b0;
         EX_DmWr     <= 1'b0;
         EX_ReadMen  <= 1'b0;
         EX_WbSel    <= '0;
         EX_Rw       <= '0;
         exRs        <= '0;
         exRt        <= '0;
         exUseRs     <= 1'b0;
         exUseRt     <= 1'b0;
         MEM_RfWr    <= 1'b0;
         MEM_DmWr    <= 1'b0;
         MEM_ReadMen <= 1'b0;
         MEM_WbSel   <= '0;
         MEM_Rw      <= '0;
         WB_RfWr     <= 1'b0;
         WB_WbSel    <= '0;
         WB_Rw       <= '0;
      end else if (!Mem_Busy) begin
         WB_RfWr     <= MEM_RfWr;
         WB_WbSel    <= MEM_WbSel;
         WB_Rw       <= MEM_Rw;
         MEM_RfWr    <= EX_RfWr;
         MEM_DmWr    <= EX_DmWr;
         MEM_ReadMen <= EX_ReadMen;
         MEM_WbSel   <= EX_WbSel;
         MEM_Rw      <= EX_Rw;
         if (hazStall) begin
            EX_RfWr    <= 1'b0;
            EX_DmWr    <= 1'b0;
            EX_ReadMen <= 1'b0;
            EX_WbSel   <= '0;
            EX_Rw      <= '0;
            exRs       <= '0;
            exRt       <= '0;
            exUseRs    <= 1'b0;
            exUseRt    <= 1'b0;
         end else begin
            EX_RfWr    <= ID_RfWr && (ID_Rw != '0);
            EX_DmWr    <= ID_DmWr;
            EX_ReadMen <= ID_ReadMen;
            EX_WbSel   <= ID_WbSel;
            EX_Rw      <= ID_Rw;
            exRs       <= ID_Rs;
            exRt       <= ID_Rt;
            exUseRs    <= ID_UseRs;
            exUseRt    <= ID_UseRt;
         end
      end
   end

`ifdef PIPE_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     Stall_Cnt <= '0;
      else if (Stall) Stall_Cnt <= Stall_Cnt + 32'd1;
   end
`else
   assign Stall_Cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Directed bench for pipe_ctrl_hazard: reset, latency, load-use, forwarding, branch hazards, freeze.
module tb_pipe_ctrl_hazard;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        ID_RfWr, ID_DmWr, ID_ReadMen, ID_UseRs, ID_UseRt, ID_IsBranch, Mem_Busy;
   logic [1:0]  ID_WbSel;
   logic [4:0]  ID_Rw, ID_Rs, ID_Rt;
   logic        Stall, EX_RfWr, EX_DmWr, EX_ReadMen, MEM_RfWr, MEM_DmWr, MEM_ReadMen, WB_RfWr;
   logic [1:0]  EX_WbSel, MEM_WbSel, WB_WbSel, FwdA_EX, FwdB_EX, FwdA_ID, FwdB_ID;
   logic [4:0]  EX_Rw, MEM_Rw, WB_Rw;
   logic [31:0] Stall_Cnt;
   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   pipe_ctrl_hazard #(.RW_W(5), .WB_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .ID_RfWr(ID_RfWr), .ID_DmWr(ID_DmWr), .ID_ReadMen(ID_ReadMen), .ID_WbSel(ID_WbSel),
      .ID_Rw(ID_Rw), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
      .ID_IsBranch(ID_IsBranch), .Mem_Busy(Mem_Busy), .Stall(Stall),
      .EX_RfWr(EX_RfWr), .EX_DmWr(EX_DmWr), .EX_ReadMen(EX_ReadMen), .EX_WbSel(EX_WbSel), .EX_Rw(EX_Rw),
      .MEM_RfWr(MEM_RfWr), .MEM_DmWr(MEM_DmWr), .MEM_ReadMen(MEM_ReadMen), .MEM_WbSel(MEM_WbSel),
      .MEM_Rw(MEM_Rw), .WB_RfWr(WB_RfWr), .WB_WbSel(WB_WbSel), .WB_Rw(WB_Rw),
      .FwdA_EX(FwdA_EX), .FwdB_EX(FwdB_EX), .FwdA_ID(FwdA_ID), .FwdB_ID(FwdB_ID),
      .Stall_Cnt(Stall_Cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // rfWr, dmWr, readMen, wbSel, rw, rs, rt, useRs, useRt, isBranch
   task automatic setId(input logic rf, input logic dm, input logic rd, input logic [1:0] wb,
                        input logic [4:0] rw, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic br);
      ID_RfWr = rf; ID_DmWr = dm; ID_ReadMen = rd; ID_WbSel = wb; ID_Rw = rw;
      ID_Rs = rs; ID_Rt = rt; ID_UseRs = urs; ID_UseRt = urt; ID_IsBranch = br;
      #1;
   endtask

   task automatic nop();
      setId(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      nop();
      repeat (3) step();
   endtask

   initial begin
      rst_n = 1'b0;
      Mem_Busy = 1'b0;
      setId(1, 0, 0, 2'b01, 5, 0, 0, 0, 0, 0);
      repeat (3) step();
      chk("rst_EX_Rw", EX_Rw, 0);
      chk("rst_EX_RfWr", EX_RfWr, 0);
      chk("rst_WB_Rw", WB_Rw, 0);
      chk("rst_Stall", Stall, 0);
      chk("rst_FwdA_EX", FwdA_EX, 0);
      chk("rst_Cnt", Stall_Cnt, 0);
      rst_n = 1'b1;
      step();
      chk("lat_EX_Rw", EX_Rw, 5);
      chk("lat_EX_RfWr", EX_RfWr, 1);
      nop();
      step();
      chk("lat_MEM_Rw", MEM_Rw, 5);
      chk("lat_EX_Rw_bubble", EX_Rw, 0);
      step();
      chk("lat_WB_Rw", WB_Rw, 5);
      chk("lat_WB_RfWr", WB_RfWr, 1);
      step();
      chk("lat_WB_drop", WB_Rw, 0);

      // load-use: lw r3 ; add r8, r3, r2
      setId(1, 0, 1, 2'b00, 3, 0, 0, 0, 0, 0);
      step();
      setId(1, 0, 0, 2'b01, 8, 3, 2, 1, 1, 0);
      chk("lu_Stall", Stall, 1);
      step();
      chk("lu_EX_RfWr", EX_RfWr, 0);
      chk("lu_EX_ReadMen", EX_ReadMen, 0);
      chk("lu_MEM_Rw", MEM_Rw, 3);
      chk("lu_Stall_clear", Stall, 0);
      step();
      chk("lu_EX_Rw", EX_Rw, 8);
      chk("lu_FwdA_EX", FwdA_EX, 2'b10);
      chk("lu_FwdB_EX", FwdB_EX, 2'b00);

      // add r4 ; sub r9, r8, r4  (r4 from MEM, r8 from WB)
      setId(1, 0, 0, 2'b01, 4, 0, 0, 0, 0, 0);
      step();
      setId(1, 0, 0, 2'b01, 9, 8, 4, 1, 1, 0);
      chk("alu_Stall", Stall, 0);
      step();
      nop();
      chk("alu_FwdB_EX", FwdB_EX, 2'b01);
      chk("alu_FwdA_EX", FwdA_EX, 2'b10);
      flush();

      // addi r6 ; beq r6, r0
      setId(1, 0, 0, 2'b01, 6, 0, 0, 0, 0, 0);
      step();
      setId(0, 0, 0, 2'b00, 0, 6, 0, 1, 1, 1);
      chk("bra_Stall", Stall, 1);
      chk("bra_FwdA_ID_ex", FwdA_ID, 2'b00);
      step();
      chk("bra_Stall_clear", Stall, 0);
      chk("bra_FwdA_ID", FwdA_ID, 2'b01);
      chk("bra_FwdB_ID", FwdB_ID, 2'b00);
      flush();

      // lw r7 ; beq r7
      setId(1, 0, 1, 2'b00, 7, 0, 0, 0, 0, 0);
      step();
      setId(0, 0, 0, 2'b00, 0, 7, 0, 1, 0, 1);
      chk("brl_Stall1", Stall, 1);
      step();
      chk("brl_Stall2", Stall, 1);
      chk("brl_FwdA_ID_mem", FwdA_ID, 2'b00);
      step();
      chk("brl_Stall_clear", Stall, 0);
      chk("brl_FwdA_ID", FwdA_ID, 2'b10);
      flush();

      // r0 destinations are invisible downstream
      setId(1, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0);
      step();
      chk("r0_EX_RfWr", EX_RfWr, 0);
      chk("r0_EX_ReadMen", EX_ReadMen, 1);
      setId(0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 1);
      chk("r0_Stall", Stall, 0);
      step();
      chk("r0_FwdA_ID", FwdA_ID, 2'b00);
      flush();

      // freeze with pending load-use; counter restarted by a reset pulse
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      setId(1, 0, 1, 2'b00, 3, 0, 0, 0, 0, 0);
      step();
      setId(1, 0, 0, 2'b01, 8, 3, 0, 1, 0, 0);
      Mem_Busy = 1'b1;
      #1;
      chk("frz_Stall0", Stall, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("frz_Stall", Stall, 1);
         chk("frz_EX_Rw", EX_Rw, 3);
         chk("frz_EX_ReadMen", EX_ReadMen, 1);
         chk("frz_MEM_Rw", MEM_Rw, 0);
      end
      Mem_Busy = 1'b0;
      #1;
      chk("frz_lu_Stall", Stall, 1);
      step();
      chk("frz_EX_bubble", EX_RfWr, 0);
      chk("frz_MEM_Rw_after", MEM_Rw, 3);
      chk("frz_Stall_clear", Stall, 0);
`ifdef PIPE_STALL_CNT_EN
      chk("frz_Cnt", Stall_Cnt, 4);
`else
      chk("frz_Cnt", Stall_Cnt, 0);
`endif
      nop();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
